// File: rtl/miriscv_mem_arbiter.sv
// Two-master (fetch/LSU) arbiter onto a single in-order memory port with an owner FIFO for response routing.
// Define MIRISCV_ARB_FAIRNESS_EN to force a waiting fetch through after STARVE_LIMIT consecutive data grants.
module miriscv_mem_arbiter #(
   parameter int OUTSTANDING  = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        instr_req_i,
   input  logic [31:0] instr_addr_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   output logic [31:0] instr_rdata_o,
   input  logic        data_req_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i
);

   localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
   localparam int CNT_W = $clog2(OUTSTANDING + 1);
   localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(OUTSTANDING);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(OUTSTANDING - 1);

   logic [CNT_W-1:0]       count;
   logic [PTR_W-1:0]       wr_ptr;
   logic [PTR_W-1:0]       rd_ptr;
   logic [OUTSTANDING-1:0] owner_fifo;
   logic                   lock;
   logic                   lock_owner;
   logic                   sel_data;
   logic                   grant;
   logic                   pop;
   logic                   head;
   logic                   has_pending;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      if (p == LAST_PTR) return '0;
      return p + 1'b1;
   endfunction

`ifdef MIRISCV_ARB_FAIRNESS_EN
   localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [STARVE_W-1:0] STARVE_LAST = STARVE_W'(STARVE_LIMIT - 1);
   localparam logic [STARVE_W-1:0] STARVE_MAX  = STARVE_W'(STARVE_LIMIT);

   logic [STARVE_W-1:0] starve_cnt;
   logic                force_instr;

   // Force flag is sticky until the fetch actually wins, even if the LSU goes quiet meanwhile.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         starve_cnt  <= '0;
         force_instr <= 1'b0;
      end else if (instr_gnt_o) begin
         starve_cnt  <= '0;
         force_instr <= 1'b0;
      end else if (!instr_req_i) begin
         starve_cnt  <= '0;
      end else if (data_gnt_o && (starve_cnt != STARVE_MAX)) begin
         starve_cnt <= starve_cnt + 1'b1;
         if (starve_cnt == STARVE_LAST) force_instr <= 1'b1;
      end
   end
`endif

   always_comb begin
      sel_data = 1'b0;
      if (lock) sel_data = lock_owner;
`ifdef MIRISCV_ARB_FAIRNESS_EN
      else if (force_instr && instr_req_i) sel_data = 1'b0;
`endif
      else if (data_req_i) sel_data = 1'b1;
   end

   assign has_pending = (count != '0);
   assign mem_req_o   = (instr_req_i | data_req_i) & (count < MAX_CNT) & ~rst_i;
   assign grant       = mem_req_o & mem_gnt_i;
   assign instr_gnt_o = grant & ~sel_data;
   assign data_gnt_o  = grant & sel_data;

   assign mem_we_o    = sel_data ? data_we_i    : 1'b0;
   assign mem_be_o    = sel_data ? data_be_i    : 4'hF;
   assign mem_addr_o  = sel_data ? data_addr_i  : instr_addr_i;
   assign mem_wdata_o = sel_data ? data_wdata_i : 32'h0;

   // While locked only the owner can be selected, so any grant is necessarily the owner's.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lock       <= 1'b0;
         lock_owner <= 1'b0;
      end else if (grant) begin
         lock <= 1'b0;
      end else if (mem_req_o) begin
         lock       <= 1'b1;
         lock_owner <= sel_data;
      end
   end

   assign pop  = mem_rvalid_i & has_pending & ~rst_i;
   assign head = owner_fifo[rd_ptr];

   always_ff @(posedge clk_i) begin
      if (grant) owner_fifo[wr_ptr] <= sel_data;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (grant) wr_ptr <= ptr_next(wr_ptr);
         if (pop)   rd_ptr <= ptr_next(rd_ptr);
         if (grant && !pop)      count <= count + 1'b1;
         else if (pop && !grant) count <= count - 1'b1;
      end
   end

   assign instr_rvalid_o = pop & ~head;
   assign data_rvalid_o  = pop & head;
   assign instr_rdata_o  = mem_rdata_i;
   assign data_rdata_o   = mem_rdata_i;

endmodule

// File: tb/tb_miriscv_mem_arbiter.sv
// Scoreboard bench for miriscv_mem_arbiter: stimulus queues expected grants/responses, a negedge monitor checks them.
// Fairness expectations follow MIRISCV_ARB_FAIRNESS_EN when the bench is built with it.
module tb_miriscv_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_req;
   logic [31:0] instr_addr;
   logic        instr_gnt;
   logic        instr_rvalid;
   logic [31:0] instr_rdata;
   logic        data_req;
   logic        data_we;
   logic [3:0]  data_be;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_gnt;
   logic        data_rvalid;
   logic [31:0] data_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   typedef struct {
      bit          is_data;
      logic [31:0] val;
   } exp_t;

   exp_t exp_gnt[$];
   exp_t exp_rsp[$];
   exp_t mon_e;
   int   compared   = 0;
   int   mismatched = 0;
   bit   owner_hist[16];
   bit   is_d;

   always #5 clk = ~clk;

   miriscv_mem_arbiter #(.OUTSTANDING(2), .STARVE_LIMIT(4)) dut (
      .clk_i(clk), .rst_i(rst),
      .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(instr_gnt),
      .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata),
      .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be),
      .data_addr_i(data_addr), .data_wdata_i(data_wdata), .data_gnt_o(data_gnt),
      .data_rvalid_o(data_rvalid), .data_rdata_o(data_rdata),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
      end
   endtask

   // One cycle: drive just after the rising edge, return at the falling edge for sampling.
   task automatic applyStimulus(input logic r, input logic ireq, input logic [31:0] iaddr,
                                input logic dreq, input logic dwe, input logic [3:0] dbe,
                                input logic [31:0] daddr, input logic [31:0] dwdata,
                                input logic gnt, input logic rv, input logic [31:0] rdata);
      @(posedge clk);
      #1;
      rst        = r;
      instr_req  = ireq;
      instr_addr = iaddr;
      data_req   = dreq;
      data_we    = dwe;
      data_be    = dbe;
      data_addr  = daddr;
      data_wdata = dwdata;
      mem_gnt    = gnt;
      mem_rvalid = rv;
      mem_rdata  = rdata;
      @(negedge clk);
   endtask

   task automatic idleCycle(input logic r);
      applyStimulus(r, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic memResp(input logic [31:0] rdata);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, rdata);
   endtask

   task automatic pushGnt(input bit d, input logic [31:0] addr);
      exp_gnt.push_back('{d, addr});
   endtask

   task automatic pushRsp(input bit d, input logic [31:0] rdata);
      exp_rsp.push_back('{d, rdata});
   endtask

   // Every grant and every response the DUT presents must match the head of its queue.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (instr_gnt || data_gnt) begin
            if (exp_gnt.size() == 0) begin
               checkOutput("unexpected_gnt", {30'h0, data_gnt, instr_gnt}, 32'h0);
            end else begin
               mon_e = exp_gnt.pop_front();
               checkOutput("gnt_owner", {30'h0, data_gnt, instr_gnt}, mon_e.is_data ? 32'h2 : 32'h1);
               checkOutput("gnt_addr", mem_addr, mon_e.val);
            end
         end
         if (instr_rvalid || data_rvalid) begin
            if (exp_rsp.size() == 0) begin
               checkOutput("unexpected_rsp", {30'h0, data_rvalid, instr_rvalid}, 32'h0);
            end else begin
               mon_e = exp_rsp.pop_front();
               checkOutput("rsp_owner", {30'h0, data_rvalid, instr_rvalid}, mon_e.is_data ? 32'h2 : 32'h1);
               checkOutput("rsp_rdata", mon_e.is_data ? data_rdata : instr_rdata, mon_e.val);
            end
         end
      end
   end

   initial begin
      rst = 1'b1; instr_req = 1'b0; instr_addr = '0; data_req = 1'b0; data_we = 1'b0;
      data_be = '0; data_addr = '0; data_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

      // Reset: all handshake outputs held low even with everything asserted.
      applyStimulus(1'b1, 1'b1, 32'h10, 1'b1, 1'b1, 4'hF, 32'h20, 32'h0, 1'b1, 1'b1, 32'hDEAD);
      checkOutput("rst_mem_req", mem_req, 32'h0);
      checkOutput("rst_instr_gnt", instr_gnt, 32'h0);
      checkOutput("rst_data_gnt", data_gnt, 32'h0);
      checkOutput("rst_instr_rvalid", instr_rvalid, 32'h0);
      checkOutput("rst_data_rvalid", data_rvalid, 32'h0);
      idleCycle(1'b1);

      // Simultaneous requests: data first, fetch next cycle; then in-order responses and a stray rvalid.
      pushGnt(1'b1, 32'h200);
      applyStimulus(1'b0, 1'b1, 32'h104, 1'b1, 1'b1, 4'h3, 32'h200, 32'hCAFE0001, 1'b1, 1'b0, 32'h0);
      checkOutput("t1_data_we", mem_we, 32'h1);
      checkOutput("t1_data_be", mem_be, 32'h3);
      checkOutput("t1_data_wdata", mem_wdata, 32'hCAFE0001);
      pushGnt(1'b0, 32'h104);
      applyStimulus(1'b0, 1'b1, 32'h104, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
      checkOutput("t1_fetch_we", mem_we, 32'h0);
      checkOutput("t1_fetch_be", mem_be, 32'hF);
      pushRsp(1'b1, 32'h11111111);
      memResp(32'h11111111);
      pushRsp(1'b0, 32'h22222222);
      memResp(32'h22222222);
      memResp(32'h33333333);
      checkOutput("t1_drop_rvalid", {data_rvalid, instr_rvalid}, 32'h0);

      // Stalled fetch keeps its address on the bus while the LSU starts requesting.
      applyStimulus(1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      checkOutput("t2_req_c1", mem_req, 32'h1);
      checkOutput("t2_addr_c1", mem_addr, 32'h100);
      for (int c = 2; c <= 3; c++) begin
         applyStimulus(1'b0, 1'b1, 32'h100, 1'b1, 1'b1, 4'hF, 32'h300, 32'h55, 1'b0, 1'b0, 32'h0);
         checkOutput("t2_addr_hold", mem_addr, 32'h100);
         checkOutput("t2_we_hold", mem_we, 32'h0);
      end
      pushGnt(1'b0, 32'h100);
      applyStimulus(1'b0, 1'b1, 32'h100, 1'b1, 1'b1, 4'hF, 32'h300, 32'h55, 1'b1, 1'b0, 32'h0);
      pushGnt(1'b1, 32'h300);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h300, 32'h55, 1'b1, 1'b0, 32'h0);
      pushRsp(1'b0, 32'h0000AAAA);
      memResp(32'h0000AAAA);
      pushRsp(1'b1, 32'h0000BBBB);
      memResp(32'h0000BBBB);

      // Full outstanding window blocks requests, including in the cycle a response pops.
      pushGnt(1'b0, 32'h400);
      applyStimulus(1'b0, 1'b1, 32'h400, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
      pushGnt(1'b1, 32'h500);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h500, 32'h0, 1'b1, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b1, 32'h404, 1'b1, 1'b0, 4'hF, 32'h504, 32'h0, 1'b1, 1'b0, 32'h0);
      checkOutput("t3_full_req", mem_req, 32'h0);
      pushRsp(1'b0, 32'hA5A5A5A5);
      applyStimulus(1'b0, 1'b1, 32'h404, 1'b1, 1'b0, 4'hF, 32'h504, 32'h0, 1'b1, 1'b1, 32'hA5A5A5A5);
      checkOutput("t3_full_req_pop", mem_req, 32'h0);
      checkOutput("t3_instr_rvalid", instr_rvalid, 32'h1);
      pushRsp(1'b1, 32'h5A5A5A5A);
      memResp(32'h5A5A5A5A);
      checkOutput("t3_data_rvalid", data_rvalid, 32'h1);

      // Grant and response together at count 1 leaves one entry outstanding.
      pushGnt(1'b0, 32'h600);
      applyStimulus(1'b0, 1'b1, 32'h600, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
      pushGnt(1'b1, 32'h700);
      pushRsp(1'b0, 32'h33330000);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'hC, 32'h700, 32'h77, 1'b1, 1'b1, 32'h33330000);
      pushRsp(1'b1, 32'h44440000);
      memResp(32'h44440000);
      memResp(32'h55550000);
      checkOutput("t4_count_zero", {data_rvalid, instr_rvalid}, 32'h0);

      // Reset with a transaction in flight discards its late response.
      pushGnt(1'b0, 32'h800);
      applyStimulus(1'b0, 1'b1, 32'h800, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b1, 32'h804, 1'b1, 1'b0, 4'hF, 32'h900, 32'h0, 1'b1, 1'b0, 32'h0);
      checkOutput("t5_rst_req", mem_req, 32'h0);
      idleCycle(1'b1);
      memResp(32'h66660000);
      checkOutput("t5_drop_after_rst", {data_rvalid, instr_rvalid}, 32'h0);

      // Continuous contention: memory answers every grant one cycle later.
      for (int k = 0; k < 15; k++) begin
`ifdef MIRISCV_ARB_FAIRNESS_EN
         is_d = ((k % 5) != 4);
`else
         is_d = 1'b1;
`endif
         pushGnt(is_d, is_d ? 32'h2000 : 32'h1000);
         if (k > 0) pushRsp(owner_hist[k-1], 32'hC0000000 + 32'(k));
         owner_hist[k] = is_d;
         applyStimulus(1'b0, 1'b1, 32'h1000, 1'b1, 1'b0, 4'hF, 32'h2000, 32'h0,
                       1'b1, (k > 0), 32'hC0000000 + 32'(k));
      end
      pushRsp(owner_hist[14], 32'hC000000F);
      memResp(32'hC000000F);
      idleCycle(1'b0);

      checkOutput("gnt_queue_empty", exp_gnt.size(), 32'h0);
      checkOutput("rsp_queue_empty", exp_rsp.size(), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
